gpio_int_collect: RTL and testbench
===================================

GPIO_INT_COLLECT -- requirements
Module: gpio_int_collect

Interface
REQ-001 Parameter CH_NUM, default 16, number of interrupt source channels (1..64).
REQ-002 Parameter SYNC_STG, default 2, synchronizer flop stages per channel (2..4).
REQ-003 Parameter ID_W, default 4, width of o_irq_id; the integrator SHALL set it to at least ceil(log2(CH_NUM)).
REQ-004 clk_cpu  input  1  sole clock; all flops on the rising edge.
REQ-005 rstn_cpu  input  1  reset; asynchronous, active-low.
REQ-006 i_int_src  input  CH_NUM  raw interrupt sources; asynchronous to clk_cpu.
REQ-007 i_mode  input  2*CH_NUM  per-channel mode [2i+1:2i]: 00 level-high, 01 rising, 10 falling, 11 both edges; quasi-static.
REQ-008 i_mask  input  CH_NUM  per-channel enable; 1 = channel may drive o_irq.
REQ-009 i_clr  input  CH_NUM  one-cycle write-1-to-clear strobes for pending and overflow bits.
REQ-010 o_pend  output  CH_NUM  registered pending flags.
REQ-011 o_irq  output  1  registered aggregate interrupt.
REQ-012 o_irq_id  output  ID_W  registered index of the lowest-numbered masked-in pending channel.
REQ-013 o_ovf  output  CH_NUM  registered sticky overflow flags.

Function
REQ-014 Each i_int_src bit SHALL pass through a SYNC_STG-deep flop chain, followed by one history flop used for edge detection.
REQ-015 An event SHALL be generated per channel from the sync output (s) and history flop (h):
- level: s=1
- rising: s&~h
- falling: ~s&h
- both: s^h
REQ-016 o_pend[i] SHALL set on the clock edge after the event is generated; a source that is stable before edge k SHALL show o_pend at edge k+SYNC_STG.
REQ-017 o_pend[i] SHALL clear on i_clr[i]=1 only when no event occurs on that channel in the same cycle; a simultaneous event wins and pend stays 1.
REQ-018 In level mode, a clear SHALL be ineffective while the synchronized level remains high.
REQ-019 i_mask SHALL NOT gate pending capture; it gates o_irq/o_irq_id only.
REQ-020 o_irq SHALL equal the registered value of |(o_pend & i_mask), one cycle after o_pend.
REQ-021 o_irq_id SHALL be registered alongside o_irq and select the lowest index in o_pend & i_mask; it SHALL be 0 when o_irq=0.
REQ-022 Changing i_mode SHALL NOT alter existing pend bits; events follow the new mode from the next cycle.
REQ-023 Mask re-enable of an already pending channel SHALL assert o_irq one cycle later, with no new event required.

Reset
REQ-024 Assertion of rstn_cpu SHALL clear the sync chains, history flops, o_pend, o_ovf, o_irq and o_irq_id to 0 immediately, independent of clk_cpu.
REQ-025 After reset release, a source already high SHALL be seen as a rising edge, and in both-edge mode as a toggle, once it propagates through the sync chain.
REQ-026 Reset mid-operation SHALL discard all pending and overflow state; no event SHALL be replayed.

Configuration
REQ-027 Macro GPIO_INT_COLLECT_OVF_EN defined: o_ovf[i] SHALL set when an edge-mode event occurs while o_pend[i]=1 and i_clr[i]=0 in that cycle.
- o_ovf[i] clears on i_clr[i] when no overflow condition occurs in the same cycle.
- Level mode never sets o_ovf.
REQ-028 Macro GPIO_INT_COLLECT_OVF_EN undefined: no overflow flops SHALL exist and o_ovf SHALL be tied to 0.

Verification
All scenarios use CH_NUM=8, SYNC_STG=2, ID_W=3.
REQ-029 Rising mode, mask=0xFF, src[3] 0->1 before edge 0 -> o_pend=0x08 at edge 2, o_irq=1 and o_irq_id=3 at edge 3; i_clr=0x08 -> pend=0 next edge, irq=0 the edge after.
REQ-030 Both-edge mode, src[5] pulsed high for 4 cycles, no clear -> pend[5]=1 after the first edge; with OVF_EN, ovf[5]=1 after the second edge; without OVF_EN, ovf stays 0.
REQ-031 Level mode, src[0] held high, i_clr=0x01 each cycle -> pend[0] stays 1; src low for 3 cycles then clr -> pend[0]=0.
REQ-032 Pend=0x24, mask=0x20 -> o_irq_id=5; mask changed to 0x24 -> o_irq_id=2 one cycle later; mask=0x00 -> o_irq=0, o_irq_id=0.
REQ-033 Falling mode, i_clr[1] and the synchronized falling edge on src[1] in the same cycle -> pend[1] remains 1 and ovf[1]=0 when pend was previously 0.
REQ-034 Assert rstn_cpu between clock edges with pend=0xFF -> all outputs 0 without any clock edge; src[7] held high through release in rising mode -> pend[7]=1 at edge 2 after release.

Source files
------------

// File: rtl/gpio_int_collect_if.sv
// Signal bundle between a GPIO interrupt collector and its register-block owner.
// The owner (master) drives sources, modes, masks and clear strobes; the collector reports status.
interface gpio_int_collect_if #(
    parameter int CH_NUM = 16,
    parameter int ID_W   = 4
);
    logic [CH_NUM-1:0]   i_int_src;
    logic [2*CH_NUM-1:0] i_mode;
    logic [CH_NUM-1:0]   i_mask;
    logic [CH_NUM-1:0]   i_clr;
    logic [CH_NUM-1:0]   o_pend;
    logic                o_irq;
    logic [ID_W-1:0]     o_irq_id;
    logic [CH_NUM-1:0]   o_ovf;

    modport master (
        output i_int_src, i_mode, i_mask, i_clr,
        input  o_pend, o_irq, o_irq_id, o_ovf
    );

    modport slave (
        input  i_int_src, i_mode, i_mask, i_clr,
        output o_pend, o_irq, o_irq_id, o_ovf
    );
endinterface

// File: rtl/gpio_int_collect.sv
// Synchronises asynchronous interrupt sources, detects level/edge events, and collects them into
// pending flags with a masked aggregate IRQ and ID. Overflow tracking: GPIO_INT_COLLECT_OVF_EN.
module gpio_int_collect #(
    parameter int CH_NUM   = 16,
    parameter int SYNC_STG = 2,
    parameter int ID_W     = 4
) (
    input  logic              clk_cpu,
    input  logic              rstn_cpu,
    gpio_int_collect_if.slave bus
);
    logic [CH_NUM-1:0] sync_q [SYNC_STG];
    logic [CH_NUM-1:0] hist_q;
    logic [CH_NUM-1:0] sync_s;
    logic [CH_NUM-1:0] evt;
    logic [CH_NUM-1:0] pend_q;
    logic [CH_NUM-1:0] act;
    logic              irq_q;
    logic [ID_W-1:0]   id_q;
    logic [ID_W-1:0]   id_nxt;

    assign sync_s = sync_q[SYNC_STG-1];

    // History flop follows the synchronizer output so edges compare consecutive synced samples.
    always_ff @(posedge clk_cpu or negedge rstn_cpu) begin
        if (!rstn_cpu) begin
            for (int k = 0; k < SYNC_STG; k++) sync_q[k] <= '0;
            hist_q <= '0;
        end else begin
            sync_q[0] <= bus.i_int_src;
            for (int k = 1; k < SYNC_STG; k++) sync_q[k] <= sync_q[k-1];
            hist_q <= sync_s;
        end
    end

    always_comb begin
        evt = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            case (bus.i_mode[2*i +: 2])
                2'b00:   evt[i] = sync_s[i];
                2'b01:   evt[i] = sync_s[i] & ~hist_q[i];
                2'b10:   evt[i] = ~sync_s[i] & hist_q[i];
                default: evt[i] = sync_s[i] ^ hist_q[i];
            endcase
        end
    end

    assign act = pend_q & bus.i_mask;

    // Scan downwards so the lowest active index is the last one written.
    always_comb begin
        id_nxt = '0;
        for (int i = CH_NUM - 1; i >= 0; i--) begin
            if (act[i]) id_nxt = ID_W'(i);
        end
    end

    // An event in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk_cpu or negedge rstn_cpu) begin
        if (!rstn_cpu) begin
            pend_q <= '0;
            irq_q  <= 1'b0;
            id_q   <= '0;
        end else begin
            pend_q <= evt | (pend_q & ~bus.i_clr);
            irq_q  <= |act;
            id_q   <= id_nxt;
        end
    end

    assign bus.o_pend   = pend_q;
    assign bus.o_irq    = irq_q;
    assign bus.o_irq_id = id_q;

`ifdef GPIO_INT_COLLECT_OVF_EN
    logic [CH_NUM-1:0] edge_mode;
    logic [CH_NUM-1:0] ovf_q;

    always_comb begin
        edge_mode = '0;
        for (int i = 0; i < CH_NUM; i++) edge_mode[i] = |bus.i_mode[2*i +: 2];
    end

    // A second edge before software acknowledges the first is an overflow.
    always_ff @(posedge clk_cpu or negedge rstn_cpu) begin
        if (!rstn_cpu) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= (ovf_q & ~bus.i_clr) | (evt & edge_mode & pend_q & ~bus.i_clr);
        end
    end

    assign bus.o_ovf = ovf_q;
`else
    assign bus.o_ovf = '0;
`endif
endmodule

// File: tb/tb_gpio_int_collect.sv
// Vector-table bench for gpio_int_collect (8 channels, 2 sync stages); each row is inputs applied
// before one rising edge and the outputs required just after it.
module tb_gpio_int_collect;
  localparam int W = 20;
`ifdef GPIO_INT_COLLECT_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  typedef struct {
    logic [7:0] src;
    logic [1:0] mode;
    logic [7:0] mask;
    logic [7:0] clr;
    logic [7:0] pend;
    logic       irq;
    logic [2:0] id;
    logic [7:0] ovf;
    logic [7:0] seg;
  } vec_t;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic [W-1:0] exp_q[$];
  vec_t vecs[$];
  int n_cmp = 0;
  int n_err = 0;

  gpio_int_collect_if #(.CH_NUM(8), .ID_W(3)) bus ();

  gpio_int_collect #(.CH_NUM(8), .SYNC_STG(2), .ID_W(3)) dut (
    .clk_cpu (clk),
    .rstn_cpu(rstn),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic void add(input logic [7:0] src, input logic [1:0] mode,
                              input logic [7:0] mask, input logic [7:0] clr,
                              input logic [7:0] pend, input logic irq,
                              input logic [2:0] id, input logic [7:0] ovf,
                              input logic [7:0] seg);
    vec_t v;
    v.src = src; v.mode = mode; v.mask = mask; v.clr = clr;
    v.pend = pend; v.irq = irq; v.id = id; v.ovf = ovf; v.seg = seg;
    vecs.push_back(v);
  endfunction

  task automatic compare(input logic [7:0] seg, input int idx);
    logic [W-1:0] got;
    logic [W-1:0] exp;
    got = {bus.o_pend, bus.o_irq, bus.o_irq_id, bus.o_ovf};
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %c%0d: scoreboard empty, got %h", seg, idx, got);
      return;
    end
    exp = exp_q.pop_front();
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %c%0d: got pend=%h irq=%b id=%0d ovf=%h, required pend=%h irq=%b id=%0d ovf=%h",
               seg, idx, got[19:12], got[11], got[10:8], got[7:0],
               exp[19:12], exp[11], exp[10:8], exp[7:0]);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    bus.i_int_src = v.src;
    bus.i_mode    = {8{v.mode}};
    bus.i_mask    = v.mask;
    bus.i_clr     = v.clr;
    exp_q.push_back({v.pend, v.irq, v.id, (OVF_EN ? v.ovf : 8'h00)});
    @(posedge clk);
    #1;
    compare(v.seg, idx);
  endtask

  initial begin
    vec_t g;
    bus.i_int_src = '0;
    bus.i_mode    = '0;
    bus.i_mask    = '0;
    bus.i_clr     = '0;

    // A: rising mode, single source, clear and IRQ drop latency
    add(8'h08, 2'b01, 8'hFF, 8'h00, 8'h00, 0, 0, 8'h00, "A");
    add(8'h08, 2'b01, 8'hFF, 8'h00, 8'h00, 0, 0, 8'h00, "A");
    add(8'h08, 2'b01, 8'hFF, 8'h00, 8'h08, 0, 0, 8'h00, "A");
    add(8'h08, 2'b01, 8'hFF, 8'h00, 8'h08, 1, 3, 8'h00, "A");
    add(8'h08, 2'b01, 8'hFF, 8'h08, 8'h00, 1, 3, 8'h00, "A");
    add(8'h08, 2'b01, 8'hFF, 8'h00, 8'h00, 0, 0, 8'h00, "A");
    add(8'h00, 2'b01, 8'hFF, 8'h00, 8'h00, 0, 0, 8'h00, "A");
    add(8'h00, 2'b01, 8'hFF, 8'h00, 8'h00, 0, 0, 8'h00, "A");
    add(8'h00, 2'b01, 8'hFF, 8'h00, 8'h00, 0, 0, 8'h00, "A");
    // B: both-edge pulse on ch5, second edge overflows
    add(8'h20, 2'b11, 8'hFF, 8'h00, 8'h00, 0, 0, 8'h00, "B");
    add(8'h20, 2'b11, 8'hFF, 8'h00, 8'h00, 0, 0, 8'h00, "B");
    add(8'h20, 2'b11, 8'hFF, 8'h00, 8'h20, 0, 0, 8'h00, "B");
    add(8'h20, 2'b11, 8'hFF, 8'h00, 8'h20, 1, 5, 8'h00, "B");
    add(8'h00, 2'b11, 8'hFF, 8'h00, 8'h20, 1, 5, 8'h00, "B");
    add(8'h00, 2'b11, 8'hFF, 8'h00, 8'h20, 1, 5, 8'h00, "B");
    add(8'h00, 2'b11, 8'hFF, 8'h00, 8'h20, 1, 5, 8'h20, "B");
    add(8'h00, 2'b11, 8'hFF, 8'h00, 8'h20, 1, 5, 8'h20, "B");
    add(8'h00, 2'b11, 8'hFF, 8'h20, 8'h00, 1, 5, 8'h00, "B");
    add(8'h00, 2'b11, 8'hFF, 8'h00, 8'h00, 0, 0, 8'h00, "B");
    // C: level mode, clear ineffective while level is high
    add(8'h01, 2'b00, 8'hFF, 8'h01, 8'h00, 0, 0, 8'h00, "C");
    add(8'h01, 2'b00, 8'hFF, 8'h01, 8'h00, 0, 0, 8'h00, "C");
    add(8'h01, 2'b00, 8'hFF, 8'h01, 8'h01, 0, 0, 8'h00, "C");
    add(8'h01, 2'b00, 8'hFF, 8'h01, 8'h01, 1, 0, 8'h00, "C");
    add(8'h01, 2'b00, 8'hFF, 8'h01, 8'h01, 1, 0, 8'h00, "C");
    add(8'h00, 2'b00, 8'hFF, 8'h00, 8'h01, 1, 0, 8'h00, "C");
    add(8'h00, 2'b00, 8'hFF, 8'h00, 8'h01, 1, 0, 8'h00, "C");
    add(8'h00, 2'b00, 8'hFF, 8'h00, 8'h01, 1, 0, 8'h00, "C");
    add(8'h00, 2'b00, 8'hFF, 8'h01, 8'h00, 1, 0, 8'h00, "C");
    add(8'h00, 2'b00, 8'hFF, 8'h00, 8'h00, 0, 0, 8'h00, "C");
    // D: ID priority under mask changes
    add(8'h24, 2'b01, 8'h20, 8'h00, 8'h00, 0, 0, 8'h00, "D");
    add(8'h24, 2'b01, 8'h20, 8'h00, 8'h00, 0, 0, 8'h00, "D");
    add(8'h24, 2'b01, 8'h20, 8'h00, 8'h24, 0, 0, 8'h00, "D");
    add(8'h24, 2'b01, 8'h20, 8'h00, 8'h24, 1, 5, 8'h00, "D");
    add(8'h24, 2'b01, 8'h24, 8'h00, 8'h24, 1, 2, 8'h00, "D");
    add(8'h24, 2'b01, 8'h00, 8'h00, 8'h24, 0, 0, 8'h00, "D");
    add(8'h24, 2'b01, 8'h00, 8'h24, 8'h00, 0, 0, 8'h00, "D");
    add(8'h24, 2'b01, 8'hFF, 8'h00, 8'h00, 0, 0, 8'h00, "D");
    add(8'h00, 2'b01, 8'hFF, 8'h00, 8'h00, 0, 0, 8'h00, "D");
    add(8'h00, 2'b01, 8'hFF, 8'h00, 8'h00, 0, 0, 8'h00, "D");
    add(8'h00, 2'b01, 8'hFF, 8'h00, 8'h00, 0, 0, 8'h00, "D");
    // E: falling edge coincident with clear
    add(8'h02, 2'b10, 8'hFF, 8'h00, 8'h00, 0, 0, 8'h00, "E");
    add(8'h02, 2'b10, 8'hFF, 8'h00, 8'h00, 0, 0, 8'h00, "E");
    add(8'h02, 2'b10, 8'hFF, 8'h00, 8'h00, 0, 0, 8'h00, "E");
    add(8'h00, 2'b10, 8'hFF, 8'h00, 8'h00, 0, 0, 8'h00, "E");
    add(8'h00, 2'b10, 8'hFF, 8'h00, 8'h00, 0, 0, 8'h00, "E");
    add(8'h00, 2'b10, 8'hFF, 8'h02, 8'h02, 0, 0, 8'h00, "E");
    add(8'h00, 2'b10, 8'hFF, 8'h00, 8'h02, 1, 1, 8'h00, "E");
    add(8'h00, 2'b10, 8'hFF, 8'h02, 8'h00, 1, 1, 8'h00, "E");
    add(8'h00, 2'b10, 8'hFF, 8'h00, 8'h00, 0, 0, 8'h00, "E");
    // F: fill all pending flags ahead of the mid-cycle reset
    add(8'hFF, 2'b01, 8'hFF, 8'h00, 8'h00, 0, 0, 8'h00, "F");
    add(8'hFF, 2'b01, 8'hFF, 8'h00, 8'h00, 0, 0, 8'h00, "F");
    add(8'hFF, 2'b01, 8'hFF, 8'h00, 8'hFF, 0, 0, 8'h00, "F");
    add(8'hFF, 2'b01, 8'hFF, 8'h00, 8'hFF, 1, 0, 8'h00, "F");

    // Reset asserted between edges with no edge yet seen
    #2 rstn = 1'b0;
    #1;
    exp_q.push_back('0);
    compare("R", 0);
    @(posedge clk);
    @(posedge clk);
    #2 rstn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Mid-cycle reset with every flag set: outputs drop with no clock edge
    @(negedge clk);
    bus.i_int_src = 8'h80;
    #2 rstn = 1'b0;
    #1;
    exp_q.push_back('0);
    compare("R", 1);
    @(posedge clk);
    #1 rstn = 1'b1;

    // Source high through release reads as a fresh rising edge; nothing else replays
    g.src = 8'h80; g.mode = 2'b01; g.mask = 8'hFF; g.clr = 8'h00; g.ovf = 8'h00; g.seg = "G";
    g.pend = 8'h00; g.irq = 1'b0; g.id = 3'd0;
    apply(g, 0);
    apply(g, 1);
    g.pend = 8'h80;
    apply(g, 2);
    g.irq = 1'b1; g.id = 3'd7;
    apply(g, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
